// File: rtl/jk_mod_counter.sv
// jk_mod_counter: synchronous modulo-N up/down counter built from a bank of
// WIDTH JK flip-flops. Every change of state is expressed as a J/K excitation
// pair per bit (toggle, hold, force-0 or force-1). The counter exposes the
// count (q), its complement (q_bar), a combinational terminal-count flag and a
// sticky wrap flag.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             a_reset,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             wrapped
);

  // Last value in the sequence, and the modulus widened by one bit so that
  // MODULUS == 2**WIDTH can still be compared against a WIDTH-bit value.
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH + 1)'(MODULUS);

  // Reject parameter combinations that cannot form a valid sequence.
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("jk_mod_counter: WIDTH %0d outside 2..16", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
    $error("jk_mod_counter: MODULUS %0d outside 2..2**WIDTH (WIDTH=%0d)",
           MODULUS, WIDTH);
  end

  // JK cell state (q of each cell).
  logic [WIDTH-1:0] r_q;
  logic             r_wrapped;

  // Excitation and helper nets.
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_inc_tgl;
  logic [WIDTH-1:0] w_dec_tgl;
  logic [WIDTH-1:0] w_up_tgl;
  logic [WIDTH-1:0] w_dn_tgl;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_up_wrap;
  logic             w_tc;

  // Status decodes on the current count. Anything at or above the last legal
  // value wraps to zero when counting up, so an out-of-range count recovers.
  assign w_at_max  = (r_q == LP_MAX);
  assign w_at_zero = (r_q == '0);
  assign w_up_wrap = (r_q >= LP_MAX);

  // Loaded values beyond the sequence are clamped to the last legal value.
  assign w_load_clamped = ({1'b0, load_val} >= LP_MOD) ? LP_MAX : load_val;

  // Plain increment/decrement toggle masks: a bit toggles when every lower
  // bit is 1 (increment carry) or every lower bit is 0 (decrement borrow).
  always_comb begin
    logic w_carry;
    logic w_borrow;
    w_inc_tgl = '0;
    w_dec_tgl = '0;
    w_carry   = 1'b1;
    w_borrow  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_inc_tgl[i] = w_carry;
      w_dec_tgl[i] = w_borrow;
      w_carry      = w_carry & r_q[i];
      w_borrow     = w_borrow & ~r_q[i];
    end
  end

  // At a wrap the toggle mask is the difference between the current value and
  // the wrap target: target 0 when counting up, LP_MAX when counting down from 0.
  assign w_up_tgl = w_up_wrap ? r_q : w_inc_tgl;
  assign w_dn_tgl = w_at_zero ? (r_q ^ LP_MAX) : w_dec_tgl;

  // J/K excitation in priority order: sync reset, load, count, hold.
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (reset) begin
      w_j = '0;
      w_k = '1;
    end else if (load) begin
      w_j = w_load_clamped;
      w_k = ~w_load_clamped;
    end else if (enable) begin
      w_j = up ? w_up_tgl : w_dn_tgl;
      w_k = up ? w_up_tgl : w_dn_tgl;
    end
  end

  // Terminal count: high exactly when the coming edge performs a wrap.
  assign w_tc = enable & ~reset & ~load &
                ((up & w_at_max) | (~up & w_at_zero));

  // JK storage cells: q+ = J & ~q | ~K & q, cleared asynchronously.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      r_q <= '0;
    end else begin
      r_q <= (w_j & ~r_q) | (~w_k & r_q);
    end
  end

  // Sticky wrap flag: set on any wrapping edge, cleared only by resets.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      r_wrapped <= 1'b0;
    end else if (reset) begin
      r_wrapped <= 1'b0;
    end else if (w_tc) begin
      r_wrapped <= 1'b1;
    end
  end

  assign count   = r_q;
  assign count_n = ~r_q;
  assign tc      = w_tc;
  assign wrapped = r_wrapped;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10): directed
// scenarios with literal expectations, then randomized stimulus, all checked
// every cycle against an arithmetic model of the counter.
module tb_jk_mod_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk;
  logic         a_reset;
  logic         reset;
  logic         enable;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic [W-1:0] count_n;
  logic         tc;
  logic         wrapped;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  // Reference model state
  int m_count;
  bit m_wrapped;

  jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk      (clk),
    .a_reset  (a_reset),
    .reset    (reset),
    .enable   (enable),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .count_n  (count_n),
    .tc       (tc),
    .wrapped  (wrapped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: next count from plain arithmetic on the rules.
  always @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      m_count   <= 0;
      m_wrapped <= 1'b0;
    end else if (reset) begin
      m_count   <= 0;
      m_wrapped <= 1'b0;
    end else if (load) begin
      m_count <= (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
    end else if (enable) begin
      if (up) m_count <= (m_count >= MOD - 1) ? 0 : m_count + 1;
      else    m_count <= (m_count == 0) ? MOD - 1 : m_count - 1;
      if ((up && m_count == MOD - 1) || (!up && m_count == 0)) m_wrapped <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit exp_tc;
      logic [W-1:0] exp_cnt;
      exp_cnt = W'(m_count);
      exp_tc  = enable && !reset && !load &&
                ((up && m_count == MOD - 1) || (!up && m_count == 0));
      checks++;
      if (count !== exp_cnt) begin
        errors++;
        $display("FAIL model_count t=%0t got=%0d exp=%0d", $time, count, exp_cnt);
      end
      checks++;
      if (count_n !== ~exp_cnt) begin
        errors++;
        $display("FAIL model_count_n t=%0t got=%h exp=%h", $time, count_n, ~exp_cnt);
      end
      checks++;
      if (tc !== exp_tc) begin
        errors++;
        $display("FAIL model_tc t=%0t got=%b exp=%b", $time, tc, exp_tc);
      end
      checks++;
      if (wrapped !== m_wrapped) begin
        errors++;
        $display("FAIL model_wrapped t=%0t got=%b exp=%b", $time, wrapped, m_wrapped);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, act, exp);
    end
  endtask

  // Apply one set of inputs across one rising edge; returns just after it.
  task automatic drive(input logic r, input logic ld, input logic [W-1:0] lv,
                       input logic en, input logic u);
    reset    = r;
    load     = ld;
    load_val = lv;
    enable   = en;
    up       = u;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int up_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_seq [3]  = '{9, 8, 7};
    int alt_seq [4] = '{3, 2, 3, 2};
    logic [W-1:0] prev;

    a_reset = 1'b1; reset = 1'b0; enable = 1'b0; up = 1'b1;
    load = 1'b0; load_val = '0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_count_n", count_n, 15);
    chk("rst_wrapped", wrapped, 0);
    @(posedge clk); #1;
    a_reset = 1'b0;
    cmp_en  = 1'b1;

    // Count up 12 edges from 0.
    for (int i = 0; i < 12; i++) begin
      reset = 1'b0; load = 1'b0; enable = 1'b1; up = 1'b1;
      #1;
      chk("up_tc", tc, (i == 9) ? 1 : 0);
      @(posedge clk); #1;
      chk("up_count", count, up_seq[i]);
      chk("up_wrapped", wrapped, (i >= 9) ? 1 : 0);
    end

    // Count down from 0 after a sync reset.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("sreset_count", count, 0);
    chk("sreset_wrapped", wrapped, 0);
    reset = 1'b0; enable = 1'b1; up = 1'b0;
    #1;
    chk("down_tc_at_zero", tc, 1);
    for (int i = 0; i < 3; i++) begin
      prev = count;
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("down_count", count, dn_seq[i]);
      if (i == 0) chk("down_wrap_toggle", int'(prev ^ count), 9);
    end
    chk("down_wrapped", wrapped, 1);

    // Loads, clamping, load overriding enable.
    drive(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    chk("load5", count, 5);
    drive(1'b0, 1'b1, 4'd13, 1'b0, 1'b0);
    chk("load13_clamp", count, 9);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 4'd13, 1'b1, 1'b1);
      chk("load_hold_count", count, 9);
      chk("load_hold_tc", tc, 0);
    end
    chk("load_keeps_wrapped", wrapped, 1);

    // Sync reset beats load and enable.
    drive(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
    chk("load4", count, 4);
    drive(1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
    chk("reset_over_load", count, 0);
    chk("reset_clears_wrapped", wrapped, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("hold_zero", count, 0);
    end

    // Alternating direction from 2.
    drive(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("alt_count", count, alt_seq[i]);
      chk("alt_tc", tc, 0);
      chk("alt_wrapped", wrapped, 0);
    end

    // Asynchronous reset mid-cycle at count 7 with wrapped set.
    drive(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("pre_areset_count", count, 7);
    chk("pre_areset_wrapped", wrapped, 1);
    #2;
    a_reset = 1'b1;
    #1;
    chk("areset_count", count, 0);
    chk("areset_count_n", count_n, 15);
    chk("areset_wrapped", wrapped, 0);
    @(posedge clk); #1;
    chk("areset_held", count, 0);
    a_reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("areset_resume", count, 1);

    // Randomized stimulus, checked by the per-cycle model comparison.
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = W'($urandom);
      enable   = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 63) == 0) begin
        #2 a_reset = 1'b1;
        #1 a_reset = 1'b0;
      end
      @(posedge clk); #1;
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter built as a bank of WIDTH JK flip-flops plus the J/K excitation logic that drives them.
- It is the excitation stage directly upstream of the JK storage cells. It converts count/load/reset commands into per-bit J/K pairs each cycle.
- It provides the team's standard decade/modulo counter for timing and sequencing. It exposes the count, its complement and terminal-count/wrap status.

Parameters:
- WIDTH, 4, number of count bits (JK cells). Legal range 2..16.
- MODULUS, 10, count sequence length. Legal range 2..2^WIDTH. The count runs 0..MODULUS-1.

Ports:
- clk  input  1  rising-edge clock.
- a_reset  input  1  asynchronous reset, active-high. Overrides everything.
- reset  input  1  synchronous reset, active-high.
- enable  input  1  count enable. When low the count holds; load and reset still act.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled only when counting.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count; the q of each JK cell.
- count_n  output  WIDTH  bitwise complement of count; the q_bar of each JK cell.
- tc  output  1  terminal count, combinational.
- wrapped  output  1  sticky wrap flag.

Behaviour:
- Storage: each bit is a JK cell. J=K=1 toggles the bit, J=K=0 holds it, and J=v, K=~v forces the bit to v.
- All next-state logic is expressed as J/K excitation. No direct D writes to count.
- Priority, highest first:
  1. a_reset
  2. reset
  3. load
  4. enable counting
  5. hold
- a_reset high: count=0, count_n=all ones and wrapped=0 immediately, with no clock required. These hold while a_reset is high. Deassertion takes effect at the next rising edge.
- reset high at an edge: count←0 and wrapped←0, regardless of enable, load or up.
- load high (reset low) at an edge:
  - count←load_val, regardless of enable.
  - If load_val ≥ MODULUS, count←MODULUS-1 (clamp).
  - wrapped is unchanged.
- Count up (enable=1, up=1, no reset or load):
  - count←count+1.
  - If count==MODULUS-1, count←0 instead.
- Count down (enable=1, up=0, no reset or load):
  - count←count-1.
  - If count==0, count←MODULUS-1 instead.
- Toggle rule for a plain increment or decrement: bit i toggles when all lower bits are 1 (up) or all 0 (down).
- Toggle rule at a wrap: bits toggle where the current value and the wrap target differ. Example: 9→0 at MODULUS=10 toggles bits 3 and 0.
- enable=0 with no reset or load: J=K=0 on every bit, so count holds.
- Latency: count updates one clock after the command edge. There is no pipeline delay beyond that.
- tc (combinational) = enable & ~reset & ~load & ((up & count==MODULUS-1) | (~up & count==0)).
- tc is high exactly in the cycle whose edge performs a wrap.
- wrapped: set at any edge where tc=1. It stays set until reset or a_reset, and load does not clear it.
- Out-of-range count: unreachable after reset. If count ≥ MODULUS is ever present:
  - Counting up goes to 0.
  - Counting down goes to count-1.
  - There is no lockup.
- count_n == ~count at all times, including during a_reset.
- Elaboration: MODULUS > 2^WIDTH or MODULUS < 2 is a parameter error, flagged with $error in the generate check.

Test Plan:
- a_reset pulse mid-count at value 7 between clock edges → count=0, count_n=4'hF and wrapped=0 immediately. Counting resumes from 0 one edge after release.
- enable=1, up=1 for 12 edges from 0 → sequence 1..9,0,1,2. tc=1 only while count=9 and enable=1. wrapped=1 from the 10th edge onward.
- enable=1, up=0 from 0 → sequence 9,8,7. tc=1 at count=0 with up=0. Observed J/K on the 0→9 edge toggles bits 3 and 0 only.
- load=1, load_val=5, enable=0 → count=5 next edge. Then load_val=13 → count=9 (clamped). load held high with enable=1 → no counting.
- reset=1 together with load=1, load_val=3, enable=1 at count=4 → count=0 and wrapped cleared. Next, enable=0 for 3 edges → count stays 0.
- up toggled every cycle with enable=1 from count=2 → 3,2,3,2. tc stays 0 and wrapped stays 0.
